// File: rtl/exu_oitf.sv
// -----------------------------------------------------------------------------
// exu_oitf -- Outstanding Instruction Track FIFO
//
// Records every long-pipe instruction (load/store, mul/div) in program order
// at dispatch and retires it in order at long-pipe write-back. From that
// record it tells the dispatch stage about RAW/WAW hazards, the itag the next
// allocation will receive, whether an entry is free and whether the FIFO is
// empty.
//
// Configuration macro:
//   OITF_WAW_DEP_EN  defined   -> oitfrd_match_disprd reports WAW hits on rd
//                    undefined -> oitfrd_match_disprd tied to 0, no compare
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dis_ena                  allocate an entry for the dispatched instruction
//   dis_ready                an entry is free (state only, no path from *_ena)
//   dis_ptr                  entry index the next allocation takes (itag)
//   disp_rs1en/rs2en/rdwen   operand / destination enables at dispatch
//   disp_rs1idx/rs2idx/rdidx register indices at dispatch
//   oitfrd_match_disprs1/2   RAW hit on rs1 / rs2
//   oitfrd_match_disprd      WAW hit on rd
//   ret_ena                  oldest entry has written back; pop it
//   ret_ptr                  index of the oldest entry
//   ret_rdwen, ret_rdidx     destination info of the oldest entry (0 if empty)
//   oitf_empty               no outstanding entries
// -----------------------------------------------------------------------------
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 1
`endif

module exu_oitf #(
   parameter int OITF_DEPTH = 2,
   parameter int OITF_PTR_W = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dis_ena,
   output logic                    dis_ready,
   output logic [OITF_PTR_W-1:0]   dis_ptr,
   input  logic                    disp_rs1en,
   input  logic                    disp_rs2en,
   input  logic                    disp_rdwen,
   input  logic [`RFIDX_WIDTH-1:0] disp_rs1idx,
   input  logic [`RFIDX_WIDTH-1:0] disp_rs2idx,
   input  logic [`RFIDX_WIDTH-1:0] disp_rdidx,
   output logic                    oitfrd_match_disprs1,
   output logic                    oitfrd_match_disprs2,
   output logic                    oitfrd_match_disprd,
   input  logic                    ret_ena,
   output logic [OITF_PTR_W-1:0]   ret_ptr,
   output logic                    ret_rdwen,
   output logic [`RFIDX_WIDTH-1:0] ret_rdidx,
   output logic                    oitf_empty
);

   localparam logic [OITF_PTR_W-1:0] PTR_MAX = OITF_PTR_W'(OITF_DEPTH - 1);

   logic [OITF_PTR_W-1:0]   alc_ptr_reg, rt_ptr_reg;
   logic                    alc_flg_reg, rt_flg_reg;
   logic [OITF_DEPTH-1:0]   vld_reg;
   logic [OITF_DEPTH-1:0]   rdwen_reg;
   logic [`RFIDX_WIDTH-1:0] rdidx_reg [OITF_DEPTH];

   logic full, empty, alc_fire, ret_fire;

   // Equal pointers: the wrap flags tell a full FIFO from an empty one.
   assign full     = (alc_ptr_reg == rt_ptr_reg) & (alc_flg_reg != rt_flg_reg);
   assign empty    = (alc_ptr_reg == rt_ptr_reg) & (alc_flg_reg == rt_flg_reg);
   assign alc_fire = dis_ena & ~full;
   assign ret_fire = ret_ena & ~empty;

   assign dis_ready  = ~full;
   assign oitf_empty = empty;
   assign dis_ptr    = alc_ptr_reg;
   assign ret_ptr    = rt_ptr_reg;
   assign ret_rdwen  = empty ? 1'b0 : rdwen_reg[rt_ptr_reg];
   assign ret_rdidx  = empty ? '0 : rdidx_reg[rt_ptr_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         alc_ptr_reg <= '0;
         alc_flg_reg <= 1'b0;
         rt_ptr_reg  <= '0;
         rt_flg_reg  <= 1'b0;
      end else begin
         if (alc_fire) begin
            alc_ptr_reg <= alc_ptr_reg + 1'b1;
            if (alc_ptr_reg == PTR_MAX) alc_flg_reg <= ~alc_flg_reg;
         end
         if (ret_fire) begin
            rt_ptr_reg <= rt_ptr_reg + 1'b1;
            if (rt_ptr_reg == PTR_MAX) rt_flg_reg <= ~rt_flg_reg;
         end
      end
   end

   logic [OITF_DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;

   genvar gi;
   generate
      for (gi = 0; gi < OITF_DEPTH; gi++) begin : g_entry
         // Allocate and retire never address the same entry in one cycle:
         // equal pointers mean full (no alloc) or empty (no retire).
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_reg[gi]   <= 1'b0;
               rdwen_reg[gi] <= 1'b0;
               rdidx_reg[gi] <= '0;
            end else if (alc_fire && (alc_ptr_reg == OITF_PTR_W'(gi))) begin
               vld_reg[gi]   <= 1'b1;
               rdwen_reg[gi] <= disp_rdwen;
               rdidx_reg[gi] <= disp_rdidx;
            end else if (ret_fire && (rt_ptr_reg == OITF_PTR_W'(gi))) begin
               vld_reg[gi]   <= 1'b0;
            end
         end

         assign hit_rs1[gi] = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == disp_rs1idx);
         assign hit_rs2[gi] = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == disp_rs2idx);
`ifdef OITF_WAW_DEP_EN
         assign hit_rd[gi]  = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == disp_rdidx);
`else
         assign hit_rd[gi]  = 1'b0;
`endif
      end
   endgenerate

   // x0 is hard-wired zero, so it never carries a dependency.
   assign oitfrd_match_disprs1 = (|hit_rs1) & disp_rs1en & (disp_rs1idx != '0);
   assign oitfrd_match_disprs2 = (|hit_rs2) & disp_rs2en & (disp_rs2idx != '0);
`ifdef OITF_WAW_DEP_EN
   assign oitfrd_match_disprd  = (|hit_rd) & disp_rdwen & (disp_rdidx != '0);
`else
   assign oitfrd_match_disprd  = 1'b0 & (|hit_rd);
`endif

`ifndef SYNTHESIS
   // Protocol checks: these events are ignored by the FIFO but indicate a
   // misbehaving neighbour.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(dis_ena && full)) else $warning("exu_oitf: dis_ena while full ignored");
         assert (!(ret_ena && empty)) else $warning("exu_oitf: ret_ena while empty ignored");
      end
   end
`endif

endmodule

// File: tb/tb_exu_oitf.sv
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 1
`endif

module tb_exu_oitf;
   logic clk = 1'b0;
   logic rst;
   logic dis_ena, dis_ready;
   logic [0:0] dis_ptr, ret_ptr;
   logic disp_rs1en, disp_rs2en, disp_rdwen;
   logic [`RFIDX_WIDTH-1:0] disp_rs1idx, disp_rs2idx, disp_rdidx;
   logic oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
   logic ret_ena, ret_rdwen, oitf_empty;
   logic [`RFIDX_WIDTH-1:0] ret_rdidx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exu_oitf #(.OITF_DEPTH(2), .OITF_PTR_W(1)) dut (
      .clk(clk), .rst(rst),
      .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
      .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
      .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
      .oitfrd_match_disprs1(oitfrd_match_disprs1),
      .oitfrd_match_disprs2(oitfrd_match_disprs2),
      .oitfrd_match_disprd(oitfrd_match_disprd),
      .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen),
      .ret_rdidx(ret_rdidx), .oitf_empty(oitf_empty)
   );

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dis_ena = 0; ret_ena = 0;
      disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
      disp_rs1idx = 0; disp_rs2idx = 0; disp_rdidx = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic alloc(input logic [`RFIDX_WIDTH-1:0] rd, input logic wen);
      dis_ena = 1; disp_rdwen = wen; disp_rdidx = rd;
      tick();
      dis_ena = 0; disp_rdwen = 0; disp_rdidx = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      tick(); tick();
      rst = 0;
      disp_rs1en = 1; disp_rs2en = 1; disp_rdwen = 1;
      disp_rs1idx = 3; disp_rs2idx = 4; disp_rdidx = 5;
      tick();
      checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", oitf_empty); end
      checks++; if (dis_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", dis_ready); end
      checks++; if (dis_ptr !== 1'b0) begin errors++; $display("FAIL reset_dis_ptr got %0d want 0", dis_ptr); end
      checks++; if (ret_ptr !== 1'b0) begin errors++; $display("FAIL reset_ret_ptr got %0d want 0", ret_ptr); end
      checks++; if ({ret_rdwen, ret_rdidx} !== 6'd0) begin errors++; $display("FAIL reset_ret_rd got %b/%0d want 0/0", ret_rdwen, ret_rdidx); end
      checks++; if ({oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd} !== 3'b000) begin
         errors++; $display("FAIL reset_match got %b%b%b want 000", oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd); end
      idle_inputs();
      $display("test_reset: idle after reset checked");
   endtask

   task automatic test_fill_full();
      do_reset();
      alloc(5'd5, 1'b1);
      checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL fill1_empty got %b want 0", oitf_empty); end
      checks++; if (dis_ptr !== 1'b1) begin errors++; $display("FAIL fill1_dis_ptr got %0d want 1", dis_ptr); end
      checks++; if (ret_rdidx !== 5'd5 || ret_rdwen !== 1'b1) begin errors++; $display("FAIL fill1_ret got %b/%0d want 1/5", ret_rdwen, ret_rdidx); end
      alloc(5'd6, 1'b1);
      checks++; if (dis_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", dis_ready); end
      checks++; if (dis_ptr !== 1'b0) begin errors++; $display("FAIL full_dis_ptr got %0d want 0", dis_ptr); end
      alloc(5'd7, 1'b1);  // ignored while full
      checks++; if (ret_rdidx !== 5'd5) begin errors++; $display("FAIL full_ignore_rdidx got %0d want 5", ret_rdidx); end
      checks++; if (dis_ready !== 1'b0 || dis_ptr !== 1'b0) begin errors++; $display("FAIL full_ignore_state got ready %b ptr %0d want 0 0", dis_ready, dis_ptr); end
      ret_ena = 1; tick();
      checks++; if (ret_ptr !== 1'b1 || ret_rdidx !== 5'd6 || dis_ready !== 1'b1) begin
         errors++; $display("FAIL pop1 got ptr %0d rd %0d ready %b want 1 6 1", ret_ptr, ret_rdidx, dis_ready); end
      tick(); ret_ena = 0;
      checks++; if (oitf_empty !== 1'b1 || ret_ptr !== 1'b0 || ret_rdidx !== 5'd0) begin
         errors++; $display("FAIL pop2 got empty %b ptr %0d rd %0d want 1 0 0", oitf_empty, ret_ptr, ret_rdidx); end
      $display("test_fill_full: fill, overflow ignore, drain checked");
   endtask

   task automatic test_raw();
      do_reset();
      // The instruction being allocated must not match itself.
      dis_ena = 1; disp_rdwen = 1; disp_rdidx = 5; disp_rs1en = 1; disp_rs1idx = 5;
      #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b0) begin errors++; $display("FAIL raw_self got %b want 0", oitfrd_match_disprs1); end
      tick();
      dis_ena = 0; disp_rdwen = 0; disp_rdidx = 0;
      #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b1) begin errors++; $display("FAIL raw_rs1 got %b want 1", oitfrd_match_disprs1); end
      disp_rs1en = 0; #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b0) begin errors++; $display("FAIL raw_rs1en0 got %b want 0", oitfrd_match_disprs1); end
      disp_rs2en = 1; disp_rs2idx = 5; #1;
      checks++; if (oitfrd_match_disprs2 !== 1'b1) begin errors++; $display("FAIL raw_rs2 got %b want 1", oitfrd_match_disprs2); end
      disp_rs2idx = 4; #1;
      checks++; if (oitfrd_match_disprs2 !== 1'b0) begin errors++; $display("FAIL raw_rs2_miss got %b want 0", oitfrd_match_disprs2); end
      idle_inputs();
      // rd=0 entry never creates a dependency.
      alloc(5'd0, 1'b1);
      disp_rs2en = 1; disp_rs2idx = 0; #1;
      checks++; if (oitfrd_match_disprs2 !== 1'b0) begin errors++; $display("FAIL raw_x0 got %b want 0", oitfrd_match_disprs2); end
      idle_inputs();
      // Entry without rdwen never matches.
      do_reset();
      alloc(5'd8, 1'b0);
      disp_rs1en = 1; disp_rs1idx = 8; #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b0 || ret_rdwen !== 1'b0 || ret_rdidx !== 5'd8) begin
         errors++; $display("FAIL raw_nowen got match %b rdwen %b rd %0d want 0 0 8", oitfrd_match_disprs1, ret_rdwen, ret_rdidx); end
      idle_inputs();
      $display("test_raw: RAW match cases checked");
   endtask

   task automatic test_simultaneous();
      do_reset();
      alloc(5'd5, 1'b1);
      dis_ena = 1; disp_rdwen = 1; disp_rdidx = 7; ret_ena = 1;
      disp_rs1en = 1; disp_rs1idx = 5; #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b1) begin errors++; $display("FAIL sim_retiring_match got %b want 1", oitfrd_match_disprs1); end
      tick();
      dis_ena = 0; ret_ena = 0; disp_rdwen = 0; #1;
      checks++; if (oitf_empty !== 1'b0 || dis_ready !== 1'b1) begin errors++; $display("FAIL sim_occ got empty %b ready %b want 0 1", oitf_empty, dis_ready); end
      checks++; if (ret_rdidx !== 5'd7 || ret_ptr !== 1'b1) begin errors++; $display("FAIL sim_ret got rd %0d ptr %0d want 7 1", ret_rdidx, ret_ptr); end
      checks++; if (oitfrd_match_disprs1 !== 1'b0) begin errors++; $display("FAIL sim_old_gone got %b want 0", oitfrd_match_disprs1); end
      disp_rs1idx = 7; #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b1) begin errors++; $display("FAIL sim_new_match got %b want 1", oitfrd_match_disprs1); end
      idle_inputs();
      $display("test_simultaneous: alloc+retire checked");
   endtask

   task automatic test_ret_empty();
      do_reset();
      ret_ena = 1; tick(); ret_ena = 0;
      checks++; if (oitf_empty !== 1'b1 || ret_ptr !== 1'b0 || dis_ptr !== 1'b0) begin
         errors++; $display("FAIL ret_empty got empty %b rptr %0d dptr %0d want 1 0 0", oitf_empty, ret_ptr, dis_ptr); end
      // Alloc + retire on empty: only the allocation happens.
      dis_ena = 1; disp_rdwen = 1; disp_rdidx = 11; ret_ena = 1;
      tick();
      idle_inputs();
      checks++; if (oitf_empty !== 1'b0 || ret_ptr !== 1'b0 || ret_rdidx !== 5'd11 || dis_ptr !== 1'b1) begin
         errors++; $display("FAIL alloc_ret_empty got empty %b rptr %0d rd %0d dptr %0d want 0 0 11 1", oitf_empty, ret_ptr, ret_rdidx, dis_ptr); end
      $display("test_ret_empty: retire-on-empty checked");
   endtask

   task automatic test_reset_mid();
      do_reset();
      alloc(5'd3, 1'b1);
      alloc(5'd4, 1'b1);
      disp_rs1en = 1; disp_rs1idx = 3; disp_rs2en = 1; disp_rs2idx = 4; #1;
      checks++; if (oitfrd_match_disprs1 !== 1'b1 || oitfrd_match_disprs2 !== 1'b1) begin
         errors++; $display("FAIL mid_pre got %b%b want 11", oitfrd_match_disprs1, oitfrd_match_disprs2); end
      rst = 1; dis_ena = 1; ret_ena = 1;   // reset wins over both strobes
      tick();
      rst = 0; dis_ena = 0; ret_ena = 0; #1;
      checks++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1 || dis_ptr !== 1'b0 || ret_ptr !== 1'b0) begin
         errors++; $display("FAIL mid_rst_state got empty %b ready %b dptr %0d rptr %0d want 1 1 0 0", oitf_empty, dis_ready, dis_ptr, ret_ptr); end
      checks++; if (oitfrd_match_disprs1 !== 1'b0 || oitfrd_match_disprs2 !== 1'b0) begin
         errors++; $display("FAIL mid_rst_match got %b%b want 00", oitfrd_match_disprs1, oitfrd_match_disprs2); end
      idle_inputs();
      $display("test_reset_mid: reset discards entries checked");
   endtask

   task automatic test_waw();
      logic exp_waw;
`ifdef OITF_WAW_DEP_EN
      exp_waw = 1'b1;
`else
      exp_waw = 1'b0;
`endif
      do_reset();
      alloc(5'd9, 1'b1);
      disp_rdwen = 1; disp_rdidx = 9; #1;
      checks++; if (oitfrd_match_disprd !== exp_waw) begin errors++; $display("FAIL waw_hit got %b want %b", oitfrd_match_disprd, exp_waw); end
      disp_rdwen = 0; #1;
      checks++; if (oitfrd_match_disprd !== 1'b0) begin errors++; $display("FAIL waw_nowen got %b want 0", oitfrd_match_disprd); end
      disp_rdwen = 1; disp_rdidx = 10; #1;
      checks++; if (oitfrd_match_disprd !== 1'b0) begin errors++; $display("FAIL waw_miss got %b want 0", oitfrd_match_disprd); end
      idle_inputs();
      $display("test_waw: WAW match checked (expected hit %b)", exp_waw);
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_fill_full();
      test_raw();
      test_simultaneous();
      test_ret_empty();
      test_reset_mid();
      test_waw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/exu_oitf.md
# exu_oitf

Outstanding Instruction Track FIFO for the EXU. It records every long-pipe instruction (load/store, mul/div) in program order at dispatch and retires it in order at long-pipe write-back. From that record it gives the dispatch stage four things: RAW/WAW hazard flags against the instruction being dispatched, the allocation tag (itag), a full/ready indication and an empty indication. It sits between exu_disp and the long-pipe write-back arbiter.

## Interface
Parameters:
- OITF_DEPTH, default 2: number of entries. Must be a power of two, at least 2.
- OITF_PTR_W, default 1: log2(OITF_DEPTH). Must equal `ITAG_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- dis_ena  in  1  allocation strobe for the dispatched long-pipe instruction (disp_oitf_ena).
- dis_ready  out  1  an entry is free (disp_oitf_ready).
- dis_ptr  out  OITF_PTR_W  index of the entry the next allocation will take (disp_oitf_ptr → itag).
- disp_rs1en, disp_rs2en, disp_rdwen  in  1 each  operand/destination enables of the instruction at dispatch.
- disp_rs1idx, disp_rs2idx, disp_rdidx  in  `RFIDX_WIDTH each  register indices of the instruction at dispatch.
- oitfrd_match_disprs1, oitfrd_match_disprs2  out  1 each  RAW hit on rs1 / rs2.
- oitfrd_match_disprd  out  1  WAW hit on rd.
- ret_ena  in  1  oldest entry completed write-back; pop it.
- ret_ptr  out  OITF_PTR_W  index of the oldest entry (compared against the returning itag by write-back).
- ret_rdwen  out  1  rdwen stored in the oldest entry.
- ret_rdidx  out  `RFIDX_WIDTH  rdidx stored in the oldest entry.
- oitf_empty  out  1  no outstanding entries.

## Operation
State:
- Allocation pointer alc_ptr with wrap bit alc_flg.
- Retire pointer rt_ptr with wrap bit rt_flg.
- Per entry: vld, rdwen, rdidx.

Status:
- full = (alc_ptr == rt_ptr) & (alc_flg != rt_flg).
- empty = (alc_ptr == rt_ptr) & (alc_flg == rt_flg).
- dis_ready = ~full. oitf_empty = empty.
- dis_ptr = alc_ptr. ret_ptr = rt_ptr.
- ret_rdwen and ret_rdidx are read from entry rt_ptr. They are 0 when empty.

Allocate (dis_ena & ~full):
- Entry alc_ptr ← {vld=1, rdwen=disp_rdwen, rdidx=disp_rdidx}.
- alc_ptr increments. On passing OITF_DEPTH-1 it wraps to 0 and alc_flg toggles.

Retire (ret_ena & ~empty):
- Entry rt_ptr: vld ← 0.
- rt_ptr increments and wraps the same way as alc_ptr.

Ignored events (state unchanged):
- dis_ena while full. A simulation-only assertion flags it.
- ret_ena while empty. A simulation-only assertion flags it.

Simultaneous allocate and retire on a non-empty, non-full OITF: both take effect and occupancy is unchanged. When the OITF is empty, only the allocation takes effect.

Match logic (combinational, from registered entries only):
- oitfrd_match_disprs1 = OR over entries of (vld & rdwen & rdidx == disp_rs1idx) & disp_rs1en & (disp_rs1idx != 0).
- oitfrd_match_disprs2 is the same term using rs2.
- oitfrd_match_disprd is the same term using disp_rdwen and disp_rdidx.
- The instruction being allocated in the current cycle is never matched against itself; it becomes visible the cycle after allocation.
- An entry being retired in the current cycle still matches in that cycle.

## Timing
- Reset values: all vld=0, pointers and flags 0. Outputs: dis_ready=1, oitf_empty=1, dis_ptr=0, ret_ptr=0, ret_rdwen=0, ret_rdidx=0, all match outputs 0.
- rst has priority over dis_ena and ret_ena in the same cycle. Asserting it mid-operation discards all outstanding entries.
- All outputs are functions of registered state plus the current disp_* inputs. There is no input-to-state bypass.
- Allocation latency: 1 cycle. The entry is visible to match logic, ret_* and oitf_empty the cycle after the dis_ena edge.
- Retire latency: 1 cycle.
- dis_ready depends on state only. It does not depend on dis_ena or ret_ena, so there is no combinational loop with exu_disp.

## Configuration
- Macro OITF_WAW_DEP_EN defined: oitfrd_match_disprd behaves as described in Operation.
- Macro OITF_WAW_DEP_EN undefined: oitfrd_match_disprd is tied to 0 and its compare logic is not generated. Write-back must then be strictly in order so that WAW hazards are impossible.

## Test plan
- Reset then idle: oitf_empty=1, dis_ready=1, dis_ptr=0, all match outputs 0.
- Depth 2: allocate rd=5, then allocate rd=6 → dis_ready=0 and dis_ptr=0 (flag wrapped). A third dis_ena is ignored; ret_rdidx stays 5.
- Entry rd=5 outstanding, dispatch rs1idx=5 with rs1en=1 → oitfrd_match_disprs1=1. Same with rs1en=0 → 0. rd=0 entry with rs2idx=0 → 0.
- Simultaneous dis_ena (rd=7) and ret_ena with one entry outstanding (rd=5) → next cycle occupancy is 1, ret_rdidx=7, ret_ptr=1.
- ret_ena while empty → no pointer change, oitf_empty stays 1. rst asserted with 2 entries valid → next cycle empty, matches 0.
- With OITF_WAW_DEP_EN defined, entry rd=9 outstanding and dispatch rdidx=9 with rdwen=1 → oitfrd_match_disprd=1. With the macro undefined → 0.
